// File: rtl/sp_ram_fifo_ctrl_if.sv
// sp_ram_fifo_ctrl_if: port bundle for sp_ram_fifo_ctrl
//   in_valid/in_ready/in_data    : upstream stream into the FIFO
//   out_valid/out_ready/out_data : downstream stream from the output buffer head
//   ram_we/ram_addr/ram_din      : single-port RAM command, ram_dout: RAM read data (1-cycle latency)
//   level                        : words held (RAM + in-flight read + output buffer)
//   slave modport = controller view, master modport = environment view
interface sp_ram_fifo_ctrl_if #(
   parameter int MEM_WIDTH  = 24,
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [MEM_WIDTH-1:0]  in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [MEM_WIDTH-1:0]  out_data;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [MEM_WIDTH-1:0]  ram_din;
   logic [MEM_WIDTH-1:0]  ram_dout;
   logic [ADDR_WIDTH+1:0] level;
   modport slave (
      input  in_valid, in_data, out_ready, ram_dout,
      output in_ready, out_valid, out_data, ram_we, ram_addr, ram_din, level
   );
   modport master (
      output in_valid, in_data, out_ready, ram_dout,
      input  in_ready, out_valid, out_data, ram_we, ram_addr, ram_din, level
   );
endinterface

// File: rtl/sp_ram_fifo_ctrl.sv
// sp_ram_fifo_ctrl: stream-to-RAM FIFO controller in front of a single-port synchronous RAM
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sp_ram_fifo_ctrl_if.slave (input stream, output stream, RAM port, level)
module sp_ram_fifo_ctrl #(
   parameter int MEM_WIDTH  = 24,
   parameter int ADDR_WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   sp_ram_fifo_ctrl_if.slave bus
);
   localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, addr_q, addr;
   logic [ADDR_WIDTH:0]   ram_cnt;
   logic [ADDR_WIDTH+1:0] level_q;
   logic [1:0]            obuf_cnt, idx;
   logic [MEM_WIDTH-1:0]  obuf [2];
   logic                  rd_inflight, not_full, obuf_empty, read_req, rd_gnt, wr_gnt, pop;
   always_comb begin
      not_full   = ram_cnt != FULL;
      obuf_empty = obuf_cnt == 2'd0;
      // only registered state feeds read_req, keeping out_ready off the in_ready path
      read_req   = (ram_cnt != '0) && ((obuf_cnt + {1'b0, rd_inflight}) < 2'd2);
      rd_gnt     = read_req && (obuf_empty || !(bus.in_valid && not_full));
      wr_gnt     = rst_n && !rd_gnt && bus.in_valid && not_full;
      pop        = !obuf_empty && bus.out_ready;
      // slot that receives captured RAM data once this cycle's pop has shifted the buffer
      idx        = obuf_cnt - 2'(pop);
      addr       = wr_gnt ? wr_ptr : rd_gnt ? rd_ptr : addr_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ram_cnt     <= '0;
         rd_inflight <= 1'b0;
         obuf_cnt    <= '0;
         obuf[0]     <= '0;
         obuf[1]     <= '0;
         level_q     <= '0;
         addr_q      <= '0;
      end else begin
         wr_ptr      <= wr_ptr + ADDR_WIDTH'(wr_gnt);
         rd_ptr      <= rd_ptr + ADDR_WIDTH'(rd_gnt);
         ram_cnt     <= ram_cnt + (ADDR_WIDTH+1)'(wr_gnt) - (ADDR_WIDTH+1)'(rd_gnt);
         rd_inflight <= rd_gnt;
         obuf_cnt    <= obuf_cnt + 2'(rd_inflight) - 2'(pop);
         obuf[0]     <= rd_inflight && idx == 2'd0 ? bus.ram_dout : pop ? obuf[1] : obuf[0];
         obuf[1]     <= rd_inflight && idx == 2'd1 ? bus.ram_dout : obuf[1];
         level_q     <= level_q + (ADDR_WIDTH+2)'(wr_gnt) - (ADDR_WIDTH+2)'(pop);
         addr_q      <= addr;
      end
   // in_ready ignores in_valid: it only drops when a pending read would pre-empt a write
   assign bus.in_ready  = rst_n && not_full && !(read_req && obuf_empty);
   assign bus.out_valid = !obuf_empty;
   assign bus.out_data  = obuf[0];
   assign bus.ram_we    = wr_gnt;
   assign bus.ram_addr  = addr;
   assign bus.ram_din   = bus.in_data;
   assign bus.level     = level_q;
endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// tb_sp_ram_fifo_ctrl: directed self-checking bench for sp_ram_fifo_ctrl with a behavioural RAM
module tb_sp_ram_fifo_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0, n_fail = 0;
   int snt = 0, rcv = 0;
   logic [7:0] wa = '0;
   logic [23:0] vec [$];
   logic [23:0] mem [256];
   sp_ram_fifo_ctrl_if #(.MEM_WIDTH(24), .ADDR_WIDTH(8)) bus ();
   sp_ram_fifo_ctrl #(.MEM_WIDTH(24), .ADDR_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      snt = 0;
      rcv = 0;
      wa = '0;
      vec.delete();
   endtask
   // pat: 0 = out_ready low, 1 = out_ready high, 2 = out_ready 1,0,0,1 repeating
   task automatic run(input int ns, input int nr, input int pat, input int limit);
      int cyc = 0;
      int st = snt + ns;
      int rt = rcv + nr;
      logic stall = 1'b0;
      logic [23:0] held = '0;
      while ((snt < st || rcv < rt) && cyc < limit) begin
         bus.in_valid = snt < st;
         bus.in_data = bus.in_valid ? vec[snt] : 24'h0;
         bus.out_ready = rcv < rt && (pat == 1 || (pat == 2 && (cyc % 4 == 0 || cyc % 4 == 3)));
         #1;
         check("level", bus.level, snt - rcv);
         check("we_vs_accept", bus.ram_we, bus.in_valid && bus.in_ready);
         if (bus.ram_we) begin
            check("waddr", bus.ram_addr, wa);
            check("wdata", bus.ram_din, bus.in_data);
         end
         if (stall) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, held);
         end
         stall = bus.out_valid && !bus.out_ready;
         held = bus.out_data;
         if (bus.out_valid && bus.out_ready) begin
            check("rdata", bus.out_data, vec[rcv]);
            rcv++;
         end
         if (bus.in_valid && bus.in_ready) begin
            snt++;
            wa++;
         end
         cyc++;
         tick();
      end
      check("run_done", snt >= st && rcv >= rt, 1);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
   endtask
   initial begin
      bus.in_valid = 1'b1;
      bus.in_data = 24'hAAAAAA;
      bus.out_ready = 1'b1;
      #3;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_ram_we", bus.ram_we, 0);
      check("rst_level", bus.level, 0);
      check("rst_ram_addr", bus.ram_addr, 0);
      check("rst_out_data", bus.out_data, 0);
      tick();
      tick();
      rst_n = 1'b1;
      // 1 + 6: three words with out_ready low; read pre-empts the second write
      bus.out_ready = 1'b0;
      #1;
      check("t1_c0_ready", bus.in_ready, 1);
      check("t1_c0_we", bus.ram_we, 1);
      check("t1_c0_addr", bus.ram_addr, 0);
      check("t1_c0_din", bus.ram_din, 24'hAAAAAA);
      tick();
      bus.in_data = 24'h111111;
      #1;
      check("t6_read_wins", bus.in_ready, 0);
      check("t6_no_we", bus.ram_we, 0);
      check("t6_rd_addr", bus.ram_addr, 0);
      check("t1_c1_valid", bus.out_valid, 0);
      check("t1_c1_level", bus.level, 1);
      tick();
      #1;
      check("t6_write_next", bus.in_ready, 1);
      check("t1_c2_we", bus.ram_we, 1);
      check("t1_c2_addr", bus.ram_addr, 1);
      check("t1_c2_valid", bus.out_valid, 0);
      tick();
      bus.in_data = 24'h5A5A5A;
      #1;
      check("t1_latency_valid", bus.out_valid, 1);
      check("t1_latency_data", bus.out_data, 24'hAAAAAA);
      check("t1_c3_level", bus.level, 2);
      check("t1_c3_we", bus.ram_we, 1);
      check("t1_c3_addr", bus.ram_addr, 2);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t1_stall_valid", bus.out_valid, 1);
         check("t1_stall_data", bus.out_data, 24'hAAAAAA);
         tick();
      end
      #1;
      check("t1_level3", bus.level, 3);
      vec = '{24'hAAAAAA, 24'h111111, 24'h5A5A5A};
      snt = 3;
      rcv = 0;
      wa = 8'd3;
      run(0, 3, 1, 30);
      #1;
      check("t1_level0", bus.level, 0);
      check("t1_empty", bus.out_valid, 0);
      // 2: fill to RAM full plus output buffer, then one pop admits one word
      do_reset();
      for (int i = 0; i < 260; i++) vec.push_back(24'(i));
      run(258, 0, 0, 1000);
      bus.in_valid = 1'b1;
      bus.in_data = vec[258];
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t2_full_ready", bus.in_ready, 0);
         check("t2_full_level", bus.level, 258);
         check("t2_full_we", bus.ram_we, 0);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      check("t2_pop_valid", bus.out_valid, 1);
      check("t2_pop_data", bus.out_data, 0);
      tick();
      rcv = 1;
      bus.out_ready = 1'b0;
      run(1, 0, 0, 20);
      bus.in_valid = 1'b1;
      bus.in_data = vec[259];
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_refull_ready", bus.in_ready, 0);
         check("t2_refull_level", bus.level, 258);
         tick();
      end
      // 3: 300 words through with out_ready high, both pointers wrap
      do_reset();
      for (int i = 0; i < 300; i++) vec.push_back(24'(i));
      run(300, 300, 1, 2000);
      check("t3_rcv", rcv, 300);
      // 4: continuous input with out_ready 1,0,0,1
      do_reset();
      for (int i = 0; i < 40; i++) vec.push_back(24'hC0FFEE ^ 24'(i * 24'h01F3A7));
      run(40, 40, 2, 1000);
      // 5: asynchronous reset mid-cycle with five words held
      do_reset();
      for (int i = 0; i < 5; i++) vec.push_back(24'h100 + 24'(i));
      run(5, 0, 0, 50);
      tick();
      bus.in_valid = 1'b1;
      bus.in_data = 24'hFFFFFF;
      #1;
      check("t5_pre_level", bus.level, 5);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", bus.out_valid, 0);
      check("t5_rst_ready", bus.in_ready, 0);
      check("t5_rst_level", bus.level, 0);
      check("t5_rst_we", bus.ram_we, 0);
      tick();
      tick();
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      snt = 0;
      rcv = 0;
      wa = '0;
      vec = '{24'h123456};
      #1;
      check("t5_post_valid", bus.out_valid, 0);
      check("t5_post_level", bus.level, 0);
      run(1, 1, 1, 20);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
